// File: rtl/spi_slave_sequencer_pkg.sv
// Shared constants for the SPI slave sequencer: shift-register modes, FSM states, R/W bit.
package spi_slave_sequencer_pkg;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_SHIFT = 2'b01;
  localparam logic [1:0] SR_LOAD  = 2'b10;

  localparam logic RW_READ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LATCH,
    ST_RD_WAIT,
    ST_RD_LOAD,
    ST_RD_SHIFT,
    ST_WR_SHIFT,
    ST_WR_COMMIT
  } state_e;

  // States in which SCLK edges move bits through the shift register.
  function automatic logic isShiftState(input state_e s);
    return (s == ST_ADDR) || (s == ST_RD_SHIFT) || (s == ST_WR_SHIFT);
  endfunction

endpackage

// File: rtl/spi_slave_sequencer_if.sv
// Bus between the transaction sequencer and the SPI slave memory datapath.
interface spi_slave_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              cs;
  logic              sclk_posedge;
  logic [DATA_W-1:0] sr_pout;
  logic [1:0]        sr_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              miso_buf;
  logic              busy;
  logic              byte_done;
  logic              abort;

  modport slave (
    input  cs, sclk_posedge, sr_pout,
    output sr_mode, mem_addr, mem_we, miso_buf, busy, byte_done, abort
  );

  modport master (
    output cs, sclk_posedge, sr_pout,
    input  sr_mode, mem_addr, mem_we, miso_buf, busy, byte_done, abort
  );
endinterface

// File: rtl/spi_slave_sequencer_bit_counter.sv
// Counts SCLK rising edges within one byte; terminal flags the last bit of the byte.
module spi_bit_counter #(
  parameter int DATA_W = 8,
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_sclk_posedge,
  output logic [CNT_W-1:0] o_count,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_count;

  assign o_terminal = i_sclk_posedge && (r_count == CNT_W'(DATA_W - 1));
  assign o_count    = r_count;

  // Self-clearing on the terminal edge so consecutive bytes start from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear || o_terminal) begin
      r_count <= '0;
    end else if (i_sclk_posedge) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_slave_sequencer.sv
// SPI slave transaction controller: decodes the command byte, then sequences burst reads/writes.
module spi_slave_sequencer
  import spi_slave_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  spi_slave_sequencer_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_memAddr;
  logic              r_rw;
  logic [LAT_W-1:0]  r_latCnt;

  logic [CNT_W-1:0]  w_count;
  logic              w_terminal;
  logic              w_clear;
  logic              w_wrLastBit;
  logic              w_abandon;
  logic              w_abort;
  logic [1:0]        w_srMode;

  assign w_clear = !isShiftState(r_state);

  spi_bit_counter #(
    .DATA_W(DATA_W)
  ) u_bitCounter (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_clear       (w_clear),
    .i_sclk_posedge(bus.sclk_posedge),
    .o_count       (w_count),
    .o_terminal    (w_terminal)
  );

  // A chip-select release on the final write bit still lets that byte commit.
  assign w_wrLastBit = (r_state == ST_WR_SHIFT) && w_terminal;
  assign w_abandon   = bus.cs && (r_state != ST_IDLE) && (r_state != ST_WR_COMMIT) && !w_wrLastBit;
  assign w_abort     = w_abandon && ((w_count != '0) || (r_state == ST_LATCH));

  always_comb begin
    w_srMode = SR_HOLD;
    if (!w_abandon) begin
      if (r_state == ST_RD_LOAD) begin
        w_srMode = SR_LOAD;
      end else if (isShiftState(r_state) && bus.sclk_posedge) begin
        w_srMode = SR_SHIFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_memAddr <= '0;
      r_rw      <= 1'b0;
      r_latCnt  <= '0;
    end else if (w_abandon) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.cs) begin
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_terminal) begin
            r_state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          r_memAddr <= ADDR_W'(bus.sr_pout[DATA_W-1:1]);
          r_rw      <= bus.sr_pout[0];
          r_latCnt  <= '0;
          r_state   <= (bus.sr_pout[0] == RW_READ) ? ST_RD_WAIT : ST_WR_SHIFT;
        end
        ST_RD_WAIT: begin
          if (r_latCnt == LAT_W'(READ_LAT - 1)) begin
            r_state <= ST_RD_LOAD;
          end else begin
            r_latCnt <= r_latCnt + LAT_W'(1);
          end
        end
        ST_RD_LOAD: begin
          r_state <= ST_RD_SHIFT;
        end
        // Each finished read byte prefetches the next address for the burst.
        ST_RD_SHIFT: begin
          if (w_terminal) begin
            r_memAddr <= r_memAddr + ADDR_W'(1);
            r_latCnt  <= '0;
            r_state   <= ST_RD_WAIT;
          end
        end
        ST_WR_SHIFT: begin
          if (w_terminal) begin
            r_state <= ST_WR_COMMIT;
          end
        end
        ST_WR_COMMIT: begin
          r_memAddr <= r_memAddr + ADDR_W'(1);
          r_state   <= bus.cs ? ST_IDLE : ST_WR_SHIFT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sr_mode   = w_srMode;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_we    = (r_state == ST_WR_COMMIT) && (r_rw != RW_READ);
  assign bus.miso_buf  = (r_state == ST_RD_SHIFT) && (r_rw == RW_READ) && !bus.cs;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.byte_done = bus.mem_we || ((r_state == ST_RD_SHIFT) && w_terminal && !bus.cs);
  assign bus.abort     = w_abort;

endmodule

// File: tb/tb_spi_slave_sequencer.sv
// Self-checking bench: transaction-level model of expected writes/reads against the sequencer.
module tb_spi_slave_sequencer;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int READ_LAT = 1;
  localparam int GAP      = 4;
  localparam int MEM_SIZE = 1 << ADDR_W;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;

  typedef enum int {TK_NONE, TK_WRITE, TK_READ} txn_kind_e;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mosi = 1'b0;
  logic [DATA_W-1:0] envSr;
  logic [DATA_W-1:0] envMem [MEM_SIZE];
  logic [DATA_W-1:0] expMem [MEM_SIZE];
  logic [DATA_W-1:0] readBits = '0;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int weCnt = 0;
  int byteDoneCnt = 0;
  int abortCnt = 0;
  int misoPulseCnt = 0;
  int loadRun = 0;
  int firstLoadCycle = -1;
  int lastPulseCycle = 0;
  bit expectIdle = 1'b0;
  txn_kind_e txnKind = TK_NONE;
  wr_t expQ [$];

  always #5 clk = ~clk;

  spi_slave_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spi_slave_sequencer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  assign bus.sr_pout = envSr;

  // Datapath stand-in: shift register and memory react to the sequencer's commands.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!reset_n) begin
      envSr <= '0;
    end else if (bus.sr_mode == MODE_SHIFT) begin
      envSr <= {envSr[DATA_W-2:0], mosi};
    end else if (bus.sr_mode == MODE_LOAD) begin
      envSr <= envMem[bus.mem_addr];
    end
    if (reset_n && bus.mem_we) begin
      envMem[bus.mem_addr] <= envSr;
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: scoreboarded writes, per-transaction invariants, event tallies.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.mem_we) begin
          weCnt++;
          checkOutput("wrExpected", expQ.size() > 0, 1);
          if (expQ.size() > 0) begin
            wr_t w;
            w = expQ.pop_front();
            checkOutput("wrAddr", bus.mem_addr, w.addr);
            checkOutput("wrData", bus.sr_pout, w.data);
          end
        end
        if (txnKind == TK_READ) checkOutput("weInRead", bus.mem_we, 0);
        if (txnKind == TK_WRITE) checkOutput("misoInWrite", bus.miso_buf, 0);
        if (txnKind != TK_NONE) checkOutput("srModeLegal", bus.sr_mode != 2'b11, 1);
        if (expectIdle) checkOutput("busyIdle", bus.busy, 0);
        if (bus.sr_mode == MODE_LOAD) begin
          loadRun++;
          checkOutput("loadRun", loadRun, 1);
          if (firstLoadCycle < 0) firstLoadCycle = cycle;
        end else begin
          loadRun = 0;
        end
        if (bus.byte_done) byteDoneCnt++;
        if (bus.abort) abortCnt++;
        if (bus.sclk_posedge && bus.miso_buf) begin
          misoPulseCnt++;
          readBits = {readBits[DATA_W-2:0], envSr[DATA_W-1]};
        end
      end
    end
  end

  task automatic applyStimulus(input logic [DATA_W-1:0] value, input int nbits, input bit csOnLast);
    for (int i = 0; i < nbits; i++) begin
      mosi = value[DATA_W-1-i];
      bus.sclk_posedge = 1'b1;
      if (csOnLast && (i == nbits - 1)) bus.cs = 1'b1;
      lastPulseCycle = cycle;
      tick();
      bus.sclk_posedge = 1'b0;
      repeat (GAP) tick();
    end
  endtask

  task automatic startTxn(input txn_kind_e kind);
    txnKind = kind;
    expectIdle = 1'b0;
    bus.cs = 1'b0;
    repeat (2) tick();
  endtask

  task automatic endTxn();
    bus.cs = 1'b1;
    repeat (3) tick();
    txnKind = TK_NONE;
    expectIdle = 1'b1;
  endtask

  task automatic writeTxn(input logic [ADDR_W-1:0] addr, input int n,
                          input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                          input logic [DATA_W-1:0] d2, input bit csOnLast);
    logic [DATA_W-1:0] dataArr [3];
    dataArr[0] = d0;
    dataArr[1] = d1;
    dataArr[2] = d2;
    startTxn(TK_WRITE);
    applyStimulus({addr, 1'b0}, DATA_W, 1'b0);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = ADDR_W'((int'(addr) + i) % MEM_SIZE);
      w.data = dataArr[i];
      expQ.push_back(w);
      expMem[w.addr] = dataArr[i];
      applyStimulus(dataArr[i], DATA_W, csOnLast && (i == n - 1));
    end
    endTxn();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_srMode"}, bus.sr_mode, 0);
    checkOutput({tag, "_memAddr"}, bus.mem_addr, 0);
    checkOutput({tag, "_memWe"}, bus.mem_we, 0);
    checkOutput({tag, "_misoBuf"}, bus.miso_buf, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_byteDone"}, bus.byte_done, 0);
    checkOutput({tag, "_abort"}, bus.abort, 0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int weBase, bdBase, abBase, misoBase, pulse8;
    bus.cs = 1'b1;
    bus.sclk_posedge = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;
    tick();
    expectIdle = 1'b1;

    // Single write: command 0x54 (addr 0x2A, W), data 0xC3.
    weBase = weCnt; bdBase = byteDoneCnt; abBase = abortCnt;
    writeTxn(7'h2A, 1, 8'hC3, 8'h00, 8'h00, 1'b0);
    checkOutput("wr1_we", weCnt - weBase, 1);
    checkOutput("wr1_byteDone", byteDoneCnt - bdBase, 1);
    checkOutput("wr1_abort", abortCnt - abBase, 0);
    checkOutput("wr1_mem", envMem[7'h2A], 8'hC3);

    // Preload mem[0x11] = 0x5A, then read it back with command 0x23.
    writeTxn(7'h11, 1, 8'h5A, 8'h00, 8'h00, 1'b0);
    weBase = weCnt; bdBase = byteDoneCnt; abBase = abortCnt; misoBase = misoPulseCnt;
    firstLoadCycle = -1;
    readBits = '0;
    startTxn(TK_READ);
    applyStimulus(8'h23, DATA_W, 1'b0);
    pulse8 = lastPulseCycle;
    applyStimulus(8'h00, DATA_W, 1'b0);
    endTxn();
    checkOutput("rd_loadOffset", firstLoadCycle - pulse8, READ_LAT + 2);
    checkOutput("rd_misoPulses", misoPulseCnt - misoBase, DATA_W);
    checkOutput("rd_dataLiteral", readBits, 8'h5A);
    checkOutput("rd_dataModel", readBits, expMem[7'h11]);
    checkOutput("rd_byteDone", byteDoneCnt - bdBase, 1);
    checkOutput("rd_we", weCnt - weBase, 0);
    checkOutput("rd_abort", abortCnt - abBase, 0);

    // Burst write crossing the top of the address space.
    weBase = weCnt; bdBase = byteDoneCnt; abBase = abortCnt;
    writeTxn(7'h7E, 3, 8'h01, 8'h02, 8'h03, 1'b0);
    checkOutput("burst_we", weCnt - weBase, 3);
    checkOutput("burst_byteDone", byteDoneCnt - bdBase, 3);
    checkOutput("burst_abort", abortCnt - abBase, 0);
    checkOutput("burst_mem7E", envMem[7'h7E], 8'h01);
    checkOutput("burst_mem7F", envMem[7'h7F], 8'h02);
    checkOutput("burst_mem00", envMem[7'h00], 8'h03);

    // Abort after three address bits, then a clean transaction.
    weBase = weCnt; abBase = abortCnt;
    startTxn(TK_WRITE);
    applyStimulus(8'hA0, 3, 1'b0);
    bus.cs = 1'b1;
    @(negedge clk);
    checkOutput("abort_pulse", bus.abort, 1);
    checkOutput("abort_busyNow", bus.busy, 1);
    @(negedge clk);
    checkOutput("abort_busyNext", bus.busy, 0);
    checkOutput("abort_cleared", bus.abort, 0);
    tick();
    txnKind = TK_NONE;
    expectIdle = 1'b1;
    checkOutput("abort_count", abortCnt - abBase, 1);
    checkOutput("abort_we", weCnt - weBase, 0);
    writeTxn(7'h05, 1, 8'h77, 8'h00, 8'h00, 1'b0);
    checkOutput("postAbort_mem", envMem[7'h05], 8'h77);

    // Chip select rises together with the final data bit of a write.
    weBase = weCnt; bdBase = byteDoneCnt; abBase = abortCnt;
    writeTxn(7'h10, 1, 8'h99, 8'h00, 8'h00, 1'b1);
    checkOutput("edge_we", weCnt - weBase, 1);
    checkOutput("edge_byteDone", byteDoneCnt - bdBase, 1);
    checkOutput("edge_abort", abortCnt - abBase, 0);
    checkOutput("edge_mem", envMem[7'h10], 8'h99);

    // Synchronous reset in the middle of a read byte.
    startTxn(TK_READ);
    applyStimulus(8'h23, DATA_W, 1'b0);
    applyStimulus(8'h00, 4, 1'b0);
    @(negedge clk);
    checkOutput("midRead_miso", bus.miso_buf, 1);
    checkOutput("midRead_addr", bus.mem_addr, 7'h11);
    tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    checkAllZero("midReset");
    tick();
    bus.cs = 1'b1;
    txnKind = TK_NONE;
    reset_n = 1'b1;
    repeat (2) tick();
    expectIdle = 1'b1;
    @(negedge clk);
    checkOutput("final_busy", bus.busy, 0);
    checkOutput("final_queueEmpty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_sequencer.md
Name: spi_slave_sequencer

Overview:
- Transaction controller for the SPI slave memory datapath: 8-bit shift register, 128x8 data memory, MISO output buffer.
- Decodes a command byte (7-bit address + R/W bit) framed by chip select.
- Sequences shift-register modes, memory reads and writes, and MISO drive.
- Supports multi-byte bursts with address auto-increment.
- Drops into the top level in place of the existing FSM. Consumes conditioned CS and the SCLK rising-edge pulse from the input conditioners.

Parameters:
- ADDR_W, 7, memory address width; command byte is {addr[ADDR_W-1:0], rw}.
- DATA_W, 8, shift register / memory word width; sets bit-count terminal value.
- READ_LAT, 1, clk cycles from mem_addr change to valid memory dataOut.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- cs  in  1  conditioned chip select, active low.
- sclk_posedge  in  1  one-clk pulse per SCLK rising edge.
- sr_pout  in  DATA_W  shift register parallel output.
- sr_mode  out  2  shift register mode: HOLD / SHIFT / LOAD.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_we  out  1  memory write enable, one-clk pulse.
- miso_buf  out  1  MISO output enable.
- busy  out  1  high whenever state != IDLE.
- byte_done  out  1  one-clk pulse per completed data byte (read or write).
- abort  out  1  one-clk pulse when CS deasserts mid-byte.

Behaviour:
- Reset (reset_n low at posedge clk): state IDLE, bit counter 0, mem_addr 0, rw 0. All outputs 0; sr_mode = HOLD.
- sr_mode is combinational from state and sclk_posedge.
  - SHIFT only in the cycle sclk_posedge=1 while in ADDR / RD_SHIFT / WR_SHIFT.
  - LOAD only in RD_LOAD.
  - HOLD otherwise.
- IDLE: on cs=0, go to ADDR and clear the bit counter.
- ADDR: count sclk_posedge. On the DATA_W-th pulse, go to LATCH.
- LATCH (1 clk): mem_addr <= sr_pout[DATA_W-1:1]; rw <= sr_pout[0]. Next state is RD_WAIT if rw=1, else WR_SHIFT.
- RD_WAIT: READ_LAT clk, then RD_LOAD.
- RD_LOAD: 1 clk, sr_mode=LOAD, then RD_SHIFT.
- RD_SHIFT:
  - miso_buf=1 for the entire state.
  - On the DATA_W-th pulse: byte_done=1, mem_addr <= mem_addr+1, go to RD_WAIT.
- WR_SHIFT: on the DATA_W-th pulse, go to WR_COMMIT.
- WR_COMMIT (1 clk): mem_we=1 (memory takes dataIn=sr_pout at current mem_addr), byte_done=1. Next cycle mem_addr <= mem_addr+1 and state WR_SHIFT.
- Address increment wraps modulo 2^ADDR_W (127 -> 0).
- Bit counter clears on entry to every shift state.
- cs=1 in any state except IDLE and WR_COMMIT:
  - next state IDLE, same cycle sr_mode=HOLD, miso_buf=0.
  - abort=1 if bit counter != 0 or state is ADDR/LATCH with bits received; no abort on clean byte-boundary deassert.
- cs=1 coinciding with the DATA_W-th pulse in WR_SHIFT: the write completes (WR_COMMIT executes, mem_we=1), then IDLE; no abort.
- cs=1 during WR_COMMIT: commit completes, then IDLE.
- sclk_posedge outside ADDR/RD_SHIFT/WR_SHIFT is ignored; the master guarantees ≥ READ_LAT+2 clk between bytes, which the conditioner delay satisfies.
- mem_we never asserts in read transactions. miso_buf never asserts in write transactions.
- Synchronous reset mid-transaction wins over all other conditions.

Decomposition:
- Shared constants header spi_defs:
  - SR_HOLD=2'b00, SR_SHIFT=2'b01, SR_LOAD=2'b10.
  - State encodings: IDLE, ADDR, LATCH, RD_WAIT, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT.
  - RW_READ=1'b1.
- One sub-module: spi_bit_counter.
  - Inputs: clk, reset_n, clear, sclk_posedge.
  - Outputs: count, terminal (combinational, high on the DATA_W-th pulse).

Test Plan:
- Write single byte: cs low, shift 0x54 (addr 0x2A, W), shift 0xC3, cs high → one mem_we pulse with mem_addr=0x2A, sr_pout=0xC3; byte_done once; abort never; miso_buf 0 throughout.
- Read single byte: preload mem[0x11]=0x5A; shift 0x23 (addr 0x11, R) → sr_mode=LOAD exactly one clk, READ_LAT+1 clk after LATCH; miso_buf=1 for 8 SCLK; MISO stream 0x5A MSB first.
- Burst write with wrap: addr 0x7E, W, data 0x01,0x02,0x03 → writes at 0x7E, 0x7F, 0x00; three byte_done pulses.
- Abort: cs high after 3 address bits → abort pulse, IDLE next clk, no mem_we. Next transaction decodes correctly from bit 0.
- Boundary: cs rises on the same clk as the 8th data pulse of a write → mem_we still pulses once, no abort; reset_n low mid-read → all outputs 0, mem_addr 0 next clk.
